// File: rtl/onehot_hold_decoder.sv
// ============================================================================
// Module      : onehot_hold_decoder
// Description : Decodes a binary channel/beam index into a registered one-hot
//               flag vector and holds it for hold_len+1 cycles so downstream
//               trigger/snapshot logic sees a stable window. A new valid
//               index during a hold retriggers the window. Out-of-range
//               indices raise a one-cycle err pulse and are otherwise ignored.
//               Optional macro ONEHOT_HOLD_ACCUM_EN: a retrigger ORs the new
//               bit into the held vector (multi-hot) instead of replacing it.
//               DOUT_WIDTH must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_hold_decoder #(
    parameter int DOUT_WIDTH = 32,
    parameter int DIN_WIDTH  = $clog2(DOUT_WIDTH),
    parameter int HOLD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    input  logic [HOLD_WIDTH-1:0] hold_len,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Index widened by one bit so DOUT_WIDTH itself is representable; this
    // matters when DOUT_WIDTH is an exact power of two.
    localparam logic [DIN_WIDTH:0]  c_DOUT_LIMIT = (DIN_WIDTH+1)'(DOUT_WIDTH);
    localparam logic [HOLD_WIDTH-1:0] c_CNT_ONE  = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [DOUT_WIDTH-1:0]   dout_q,  dout_d;
    logic [HOLD_WIDTH-1:0]   cnt_q,   cnt_d;
    logic                    err_q,   err_d;

    logic [DIN_WIDTH:0]      w_din_ext;
    logic                    w_in_range;
    logic                    w_ev_valid;
    logic                    w_ev_invalid;
    logic [DOUT_WIDTH-1:0]   w_dec;
    logic [DOUT_WIDTH-1:0]   w_retrig_vec;

    assign w_din_ext    = {1'b0, din};
    assign w_in_range   = (w_din_ext < c_DOUT_LIMIT);
    assign w_ev_valid   = din_valid &&  w_in_range;
    assign w_ev_invalid = din_valid && !w_in_range;

    // Per-channel comparator; yields all zeros for an out-of-range index.
    genvar gi;
    generate
        for (gi = 0; gi < DOUT_WIDTH; gi++) begin : g_dec
            assign w_dec[gi] = (w_din_ext == (DIN_WIDTH+1)'(gi));
        end
    endgenerate

    // Vector loaded on a retrigger while already holding.
    generate
`ifdef ONEHOT_HOLD_ACCUM_EN
        if (1) begin : g_retrig_accum
            assign w_retrig_vec = dout_q | w_dec;
        end
`else
        if (1) begin : g_retrig_replace
            assign w_retrig_vec = w_dec;
        end
`endif
    endgenerate

    // State, flag vector, hold counter and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: a valid event always wins over hold expiry, so a
    // retrigger on the last held cycle produces no gap.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        err_d   = w_ev_invalid;

        case (state_q)
            ST_IDLE: begin
                if (w_ev_valid) begin
                    state_d = ST_HOLD;
                    dout_d  = w_dec;
                    cnt_d   = hold_len;
                end
            end
            ST_HOLD: begin
                if (w_ev_valid) begin
                    dout_d = w_retrig_vec;
                    cnt_d  = hold_len;
                end else if (cnt_q != '0) begin
                    cnt_d  = cnt_q - c_CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                    dout_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dout_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = |dout_q;
    assign busy       = (state_q == ST_HOLD);
    assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_onehot_hold_decoder.sv
// ============================================================================
// Module      : tb_onehot_hold_decoder
// Description : Self-checking bench for onehot_hold_decoder. Each stimulus
//               row carries the output expected after the clock edge that
//               samples it; expectations are queued on drive and popped and
//               compared once the edge has passed. A 32-channel and a
//               20-channel instance share the clock and index/hold inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_hold_decoder;

`ifdef ONEHOT_HOLD_ACCUM_EN
    localparam bit c_ACC = 1'b1;
`else
    localparam bit c_ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  din;
    logic        v32, v20;
    logic [15:0] hold_len;

    logic [31:0] dout32;
    logic        dv32, busy32, err32;
    logic [19:0] dout20;
    logic        dv20, busy20, err20;

    onehot_hold_decoder #(.DOUT_WIDTH(32), .HOLD_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(v32), .hold_len(hold_len),
        .dout(dout32), .dout_valid(dv32), .busy(busy32), .err(err32)
    );

    onehot_hold_decoder #(.DOUT_WIDTH(20), .HOLD_WIDTH(16)) dut20 (
        .clk(clk), .rst(rst), .din(din), .din_valid(v20), .hold_len(hold_len),
        .dout(dout20), .dout_valid(dv20), .busy(busy20), .err(err20)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dout;
        logic        dv;
        logic        busy;
        logic        err;
    } obs_t;

    typedef struct packed {
        logic [4:0]  din;
        logic        v;
        logic [15:0] hold;
        logic [31:0] edout;
        logic        ebusy;
        logic        eerr;
    } row_t;

    int   checks = 0;
    int   errors = 0;
    bit   use20  = 1'b0;
    obs_t exp_q[$];
    row_t stim_q[$];

    task automatic add(input logic [4:0] d, input logic v, input logic [15:0] h,
                       input logic [31:0] ed, input logic eb, input logic ee);
        row_t r;
        r.din = d; r.v = v; r.hold = h; r.edout = ed; r.ebusy = eb; r.eerr = ee;
        stim_q.push_back(r);
    endtask

    task automatic add_idle(input logic [31:0] ed, input logic eb);
        add(5'd0, 1'b0, 16'd0, ed, eb, 1'b0);
    endtask

    // Drive one row, queue its expectation, advance past the sampling edge.
    task automatic apply(input row_t r);
        obs_t e;
        din      = r.din;
        hold_len = r.hold;
        v32      = use20 ? 1'b0 : r.v;
        v20      = use20 ? r.v  : 1'b0;
        e.dout = r.edout; e.dv = (r.edout != 32'd0); e.busy = r.ebusy; e.err = r.eerr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t observe();
        obs_t o;
        if (use20) begin
            o.dout = {12'd0, dout20}; o.dv = dv20; o.busy = busy20; o.err = err20;
        end else begin
            o.dout = dout32; o.dv = dv32; o.busy = busy32; o.err = err32;
        end
        return o;
    endfunction

    task automatic test_reset();
        obs_t e, g;
        int   step = 0;
        rst = 1'b1; din = '0; v32 = 1'b0; v20 = 1'b0; hold_len = '0;
        @(posedge clk); #1;
        exp_q.push_back('0);
        e = exp_q.pop_front(); g = observe(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_init: got dout=%h valid=%b busy=%b err=%b, expected all zero",
                     g.dout, g.dv, g.busy, g.err);
        end
        rst = 1'b0;
        stim_q.delete();
        add(5'd9, 1'b1, 16'd50, 32'h200, 1'b1, 1'b0);
        add_idle(32'h200, 1'b1);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front(); g = observe(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_pre step %0d: got dout=%h valid=%b busy=%b err=%b, expected dout=%h valid=%b busy=%b err=%b",
                         step, g.dout, g.dv, g.busy, g.err, e.dout, e.dv, e.busy, e.err);
            end
            step++;
        end
        #2 rst = 1'b1;
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front(); g = observe(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_async: got dout=%h valid=%b busy=%b err=%b, expected all zero",
                     g.dout, g.dv, g.busy, g.err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        obs_t e, g;
        int   step = 0;
        stim_q.delete();
        add(5'd5, 1'b1, 16'd3, 32'h20, 1'b1, 1'b0);
        repeat (3) add_idle(32'h20, 1'b1);
        add_idle(32'h0, 1'b0);
        add_idle(32'h0, 1'b0);
        add(5'd31, 1'b1, 16'd0, 32'h8000_0000, 1'b1, 1'b0);
        add_idle(32'h0, 1'b0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front(); g = observe(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic step %0d: got dout=%h valid=%b busy=%b err=%b, expected dout=%h valid=%b busy=%b err=%b",
                         step, g.dout, g.dv, g.busy, g.err, e.dout, e.dv, e.busy, e.err);
            end
            step++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        int   step = 0;
        stim_q.delete();
        add(5'd0, 1'b1, 16'd0, 32'h1, 1'b1, 1'b0);
        add_idle(32'h0, 1'b0);
        add(5'd0, 1'b1, 16'd0, 32'h1, 1'b1, 1'b0);
        add(5'd1, 1'b1, 16'd0, c_ACC ? 32'h3 : 32'h2, 1'b1, 1'b0);
        add(5'd2, 1'b1, 16'd0, c_ACC ? 32'h7 : 32'h4, 1'b1, 1'b0);
        add_idle(32'h0, 1'b0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front(); g = observe(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d: got dout=%h valid=%b busy=%b err=%b, expected dout=%h valid=%b busy=%b err=%b",
                         step, g.dout, g.dv, g.busy, g.err, e.dout, e.dv, e.busy, e.err);
            end
            step++;
        end
    endtask

    task automatic test_retrigger();
        obs_t e, g;
        int   step = 0;
        stim_q.delete();
        add(5'd3, 1'b1, 16'd2, 32'h8, 1'b1, 1'b0);
        add_idle(32'h8, 1'b1);
        add_idle(32'h8, 1'b1);
        add(5'd7, 1'b1, 16'd1, c_ACC ? 32'h88 : 32'h80, 1'b1, 1'b0);
        add_idle(c_ACC ? 32'h88 : 32'h80, 1'b1);
        add_idle(32'h0, 1'b0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front(); g = observe(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL retrigger step %0d: got dout=%h valid=%b busy=%b err=%b, expected dout=%h valid=%b busy=%b err=%b",
                         step, g.dout, g.dv, g.busy, g.err, e.dout, e.dv, e.busy, e.err);
            end
            step++;
        end
    endtask

    task automatic test_out_of_range();
        obs_t e, g;
        int   step = 0;
        use20 = 1'b1;
        stim_q.delete();
        add(5'd25, 1'b1, 16'd0, 32'h0, 1'b0, 1'b1);
        add_idle(32'h0, 1'b0);
        add(5'd20, 1'b1, 16'd7, 32'h0, 1'b0, 1'b1);
        add(5'd19, 1'b1, 16'd0, 32'h8_0000, 1'b1, 1'b0);
        add_idle(32'h0, 1'b0);
        add(5'd4, 1'b1, 16'd3, 32'h10, 1'b1, 1'b0);
        add_idle(32'h10, 1'b1);
        add(5'd25, 1'b1, 16'd9, 32'h10, 1'b1, 1'b1);
        add_idle(32'h10, 1'b1);
        add_idle(32'h0, 1'b0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front(); g = observe(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL out_of_range step %0d: got dout=%h valid=%b busy=%b err=%b, expected dout=%h valid=%b busy=%b err=%b",
                         step, g.dout, g.dv, g.busy, g.err, e.dout, e.dv, e.busy, e.err);
            end
            step++;
        end
        use20 = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        obs_t e, g;
        int   step = 0;
        stim_q.delete();
        add(5'd2, 1'b1, 16'd100, 32'h4, 1'b1, 1'b0);
        repeat (9) add_idle(32'h4, 1'b1);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front(); g = observe(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mid_hold_pre step %0d: got dout=%h valid=%b busy=%b err=%b, expected dout=%h valid=%b busy=%b err=%b",
                         step, g.dout, g.dv, g.busy, g.err, e.dout, e.dv, e.busy, e.err);
            end
            step++;
        end
        #2 rst = 1'b1;
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front(); g = observe(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL mid_hold_rst: got dout=%h valid=%b busy=%b err=%b, expected all zero",
                     g.dout, g.dv, g.busy, g.err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        step = 0;
        add(5'd1, 1'b1, 16'd100, 32'h2, 1'b1, 1'b0);
        repeat (100) add_idle(32'h2, 1'b1);
        add_idle(32'h0, 1'b0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front(); g = observe(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL mid_hold_post step %0d: got dout=%h valid=%b busy=%b err=%b, expected dout=%h valid=%b busy=%b err=%b",
                         step, g.dout, g.dv, g.busy, g.err, e.dout, e.dv, e.busy, e.err);
            end
            step++;
        end
    endtask

    task automatic test_max_hold();
        obs_t e, g;
        int   step = 0;
        stim_q.delete();
        add(5'd31, 1'b1, 16'hFFFF, 32'h8000_0000, 1'b1, 1'b0);
        repeat (65535) add_idle(32'h8000_0000, 1'b1);
        add_idle(32'h0, 1'b0);
        add_idle(32'h0, 1'b0);
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            e = exp_q.pop_front(); g = observe(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL max_hold step %0d: got dout=%h valid=%b busy=%b err=%b, expected dout=%h valid=%b busy=%b err=%b",
                         step, g.dout, g.dv, g.busy, g.err, e.dout, e.dv, e.busy, e.err);
            end
            step++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_retrigger();
        test_out_of_range();
        test_reset_mid_hold();
        test_max_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
